// File: rtl/fluorescence_pkg.sv
// Shared types and helpers for the photon-counting front end.
//   pmt_state_e  : pulse-acceptance FSM states
//   pmt_event_t  : tag record queued per accepted photon
//   CNT_W        : width of the saturating readout counters
//   sat_inc()    : increment that sticks at all-ones
package fluorescence_pkg;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned PHASE_W = 32;

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    DEAD     = 2'd1,
    WAIT_LOW = 2'd2
  } pmt_state_e;

  typedef struct packed {
    logic [PHASE_W-1:0] phase;
    logic               in_phase;
    logic               quadrature;
  } pmt_event_t;

  localparam int unsigned EVENT_W = $bits(pmt_event_t);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pulse_event_fifo.sv
// Synchronous event FIFO with valid/ready read side.
//   clk_i, rst_ni : clock, async active-low reset
//   push_i/data_i : write request and payload (dropped when full unless a pop coincides)
//   valid_o/ready_i/data_o : head handshake; data_o is 0 while empty
//   level_o       : exact occupancy
//   full_o        : level_o == Depth
module pulse_event_fifo
  import fluorescence_pkg::*;
#(
  parameter int unsigned Width = EVENT_W,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [Width-1:0]         data_o,
  output logic [$clog2(Depth):0]   level_o,
  output logic                     full_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      level_q, level_d;
  logic             pop, push_ok;

  assign valid_o = (level_q != '0);
  assign full_o  = (level_q == (AW+1)'(Depth));
  assign pop     = valid_o & ready_i;
  // When full, the slot at wptr is the head being popped this cycle, so both may proceed.
  assign push_ok = push_i & (~full_o | pop);
  assign data_o  = valid_o ? mem_q[rptr_q] : '0;
  assign level_o = level_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop)     rptr_d = rptr_q + AW'(1);
    if (push_ok && !pop)      level_d = level_q + (AW+1)'(1);
    else if (!push_ok && pop) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: the output is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/pmt_pulse_capture.sv
// PMT photon front end: synchronise, glitch-filter, dead-time gate, phase-tag and queue.
//   clock_50_mhz, reset_n : clock, async active-low reset
//   PMT_in                : asynchronous discriminator input
//   light_timer, in_phase, quadrature : modulation tags sampled at detection
//   clear_counts          : zeroes pileup_count / drop_count (wins over increments)
//   event_valid/ready, event_phase/in_phase/quadrature : queued event head
//   fifo_level            : queue occupancy
//   pileup_count          : rises rejected while dead, saturating
//   drop_count            : accepted pulses lost to a full queue, saturating
module pmt_pulse_capture
  import fluorescence_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_HIGH    = 1,
  parameter int unsigned DEAD_TIME   = 5,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned PHASE_WIDTH = PHASE_W
) (
  input  logic                          clock_50_mhz,
  input  logic                          reset_n,
  input  logic                          PMT_in,
  input  logic [PHASE_WIDTH-1:0]        light_timer,
  input  logic                          in_phase,
  input  logic                          quadrature,
  input  logic                          clear_counts,
  output logic                          event_valid,
  input  logic                          event_ready,
  output logic [PHASE_WIDTH-1:0]        event_phase,
  output logic                          event_in_phase,
  output logic                          event_quadrature,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   pileup_count,
  output logic [15:0]                   drop_count
);

  localparam int unsigned FCW = $clog2(MIN_HIGH + 1);
  localparam int unsigned DCW = $clog2(DEAD_TIME + 1);
  localparam logic [FCW-1:0] MinCnt = FCW'(MIN_HIGH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [FCW-1:0]         cnt_q, cnt_d;
  logic                   f_q, f_prev_q, rise;
  pmt_state_e             state_q, state_d;
  logic [DCW-1:0]         dead_q, dead_d;
  logic                   push_q, push_d;
  pmt_event_t             tag_q, tag_d, head;
  logic [EVENT_W-1:0]     head_raw;
  logic                   fifo_full, pop, pileup_inc, drop_inc;
  logic [CNT_W-1:0]       pileup_q, pileup_d, drop_q, drop_d;

  assign s = sync_q[SYNC_STAGES-1];

  // Run-length counter: saturates at MIN_HIGH while high, clears on any low sample.
  always_comb begin
    if (!s)                  cnt_d = '0;
    else if (cnt_q == MinCnt) cnt_d = cnt_q;
    else                     cnt_d = cnt_q + FCW'(1);
  end

  assign rise = f_q & ~f_prev_q;

  always_comb begin
    state_d    = state_q;
    dead_d     = dead_q;
    push_d     = 1'b0;
    tag_d      = tag_q;
    pileup_inc = 1'b0;
    unique case (state_q)
      ARMED: begin
        if (rise) begin
          push_d           = 1'b1;
          tag_d.phase      = PHASE_W'(light_timer);
          tag_d.in_phase   = in_phase;
          tag_d.quadrature = quadrature;
          dead_d           = DCW'(DEAD_TIME - 1);
          state_d          = DEAD;
        end
      end
      DEAD: begin
        pileup_inc = rise;
        if (dead_q == '0) state_d = f_q ? WAIT_LOW : ARMED;
        else              dead_d  = dead_q - DCW'(1);
      end
      WAIT_LOW: begin
        if (!f_q) state_d = ARMED;
      end
      default: state_d = ARMED;
    endcase
  end

  assign pop      = event_valid & event_ready;
  assign drop_inc = push_q & fifo_full & ~pop;

  always_comb begin
    pileup_d = pileup_q;
    drop_d   = drop_q;
    if (clear_counts) begin
      pileup_d = '0;
      drop_d   = '0;
    end else begin
      if (pileup_inc) pileup_d = sat_inc(pileup_q);
      if (drop_inc)   drop_d   = sat_inc(drop_q);
    end
  end

  always_ff @(posedge clock_50_mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      f_q      <= 1'b0;
      f_prev_q <= 1'b0;
      state_q  <= ARMED;
      dead_q   <= '0;
      push_q   <= 1'b0;
      tag_q    <= '0;
      pileup_q <= '0;
      drop_q   <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], PMT_in};
      cnt_q    <= cnt_d;
      f_q      <= (cnt_d == MinCnt);
      f_prev_q <= f_q;
      state_q  <= state_d;
      dead_q   <= dead_d;
      push_q   <= push_d;
      tag_q    <= tag_d;
      pileup_q <= pileup_d;
      drop_q   <= drop_d;
    end
  end

  // The tag is staged one cycle before the queue, giving the fixed L = sync + filter + 1.
  pulse_event_fifo #(
    .Width (EVENT_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock_50_mhz),
    .rst_ni  (reset_n),
    .push_i  (push_q),
    .data_i  (tag_q),
    .valid_o (event_valid),
    .ready_i (event_ready),
    .data_o  (head_raw),
    .level_o (fifo_level),
    .full_o  (fifo_full)
  );

  assign head             = head_raw;
  assign event_phase      = PHASE_WIDTH'(head.phase);
  assign event_in_phase   = head.in_phase;
  assign event_quadrature = head.quadrature;
  assign pileup_count     = pileup_q;
  assign drop_count       = drop_q;

endmodule

// File: tb/tb_pmt_pulse_capture.sv
module tb_pmt_pulse_capture;
  import fluorescence_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pmt = 1'b0;
  logic [31:0] lt = '0;
  logic        in_ph = 1'b0;
  logic        quad = 1'b0;
  logic        clr = 1'b0;
  logic        ready = 1'b0;

  logic        valid, ev_i, ev_q;
  logic [31:0] phase;
  logic [3:0]  level;
  logic [15:0] pileup, drop;

  logic        valid2, ev_i2, ev_q2;
  logic [31:0] phase2;
  logic [3:0]  level2;
  logic [15:0] pileup2, drop2;

  int checks = 0;
  int failures = 0;
  int events;

  always #10 clk = ~clk;

  pmt_pulse_capture u_dut (
    .clock_50_mhz     (clk),
    .reset_n          (rst_n),
    .PMT_in           (pmt),
    .light_timer      (lt),
    .in_phase         (in_ph),
    .quadrature       (quad),
    .clear_counts     (clr),
    .event_valid      (valid),
    .event_ready      (ready),
    .event_phase      (phase),
    .event_in_phase   (ev_i),
    .event_quadrature (ev_q),
    .fifo_level       (level),
    .pileup_count     (pileup),
    .drop_count       (drop)
  );

  pmt_pulse_capture #(.MIN_HIGH(2)) u_dut2 (
    .clock_50_mhz     (clk),
    .reset_n          (rst_n),
    .PMT_in           (pmt),
    .light_timer      (lt),
    .in_phase         (in_ph),
    .quadrature       (quad),
    .clear_counts     (clr),
    .event_valid      (valid2),
    .event_ready      (ready),
    .event_phase      (phase2),
    .event_in_phase   (ev_i2),
    .event_quadrature (ev_q2),
    .fifo_level       (level2),
    .pileup_count     (pileup2),
    .drop_count       (drop2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    lt = lt + 32'd1;
  endtask

  task automatic pulse(input int high, input int low);
    pmt = 1'b1;
    repeat (high) tick();
    pmt = 1'b0;
    repeat (low) tick();
  endtask

  typedef struct {
    logic        pmt;
    logic        ready;
    logic        exp_valid;
    logic [3:0]  exp_level;
    logic [15:0] exp_pileup;
  } vec_t;

  vec_t vecs[11];

  initial begin
    // Pulse A: 3 high samples; pulse B: 1 high sample landing inside dead time.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd0, 16'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'd0, 16'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'd0, 16'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'd0, 16'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 4'd1, 16'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'd1, 16'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'd1, 16'd0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 4'd1, 16'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'd1, 16'd1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'd0, 16'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 4'd0, 16'd1};

    // Reset state
    repeat (3) tick();
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_pileup", 32'(pileup), 32'd0);
    chk("reset_drop", 32'(drop), 32'd0);
    chk("reset_phase", phase, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // One-sample glitch: rejected by MIN_HIGH=2, accepted by MIN_HIGH=1
    pulse(1, 12);
    chk("glitch_level_mh2", 32'(level2), 32'd0);
    chk("glitch_pileup_mh2", 32'(pileup2), 32'd0);
    chk("glitch_level_mh1", 32'(level), 32'd1);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("glitch_drained", 32'(level), 32'd0);
    repeat (5) tick();

    // Table: single pulse latency/tag, then a pile-up rise during dead time
    in_ph = 1'b1;
    quad  = 1'b0;
    lt    = 32'd97;
    for (int r = 0; r < 11; r++) begin
      pmt   = vecs[r].pmt;
      ready = vecs[r].ready;
      tick();
      chk($sformatf("vec%0d_valid", r), 32'(valid), 32'(vecs[r].exp_valid));
      chk($sformatf("vec%0d_level", r), 32'(level), 32'(vecs[r].exp_level));
      chk($sformatf("vec%0d_pileup", r), 32'(pileup), 32'(vecs[r].exp_pileup));
      if (r == 4) begin
        chk("tag_phase", phase, 32'd100);
        chk("tag_in_phase", 32'(ev_i), 32'd1);
        chk("tag_quadrature", 32'(ev_q), 32'd0);
      end
    end
    pmt   = 1'b0;
    ready = 1'b0;
    chk("short_pulse_in_dead_mh2", 32'(pileup2), 32'd0);
    repeat (8) tick();

    // Stuck-high input: one event, parks in WAIT_LOW until the input falls
    ready  = 1'b1;
    events = 0;
    pmt    = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (valid) events++;
      if (i == 15) chk("stuck_wait_low", 32'(u_dut.state_q), 32'(WAIT_LOW));
    end
    pmt = 1'b0;
    repeat (10) begin
      tick();
      if (valid) events++;
    end
    chk("stuck_events", 32'(events), 32'd1);
    chk("stuck_rearmed", 32'(u_dut.state_q), 32'(ARMED));
    chk("stuck_no_pileup", 32'(pileup), 32'd1);
    ready = 1'b0;

    // Clear
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clear_pileup", 32'(pileup), 32'd0);

    // Overflow: 10 pulses into an 8-deep queue
    repeat (10) pulse(3, 9);
    chk("ovf_level", 32'(level), 32'd8);
    chk("ovf_drop", 32'(drop), 32'd2);

    // Push while full with a same-cycle pop (push lands at edge k+4)
    pmt = 1'b1;
    repeat (3) tick();
    pmt = 1'b0;
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("full_pushpop_level", 32'(level), 32'd8);
    chk("full_pushpop_drop", 32'(drop), 32'd2);
    repeat (8) tick();

    // Saturation
    force u_dut.drop_q = 16'hFFFE;
    #1;
    release u_dut.drop_q;
    pulse(3, 9);
    chk("sat_reach", 32'(drop), 32'hFFFF);
    pulse(3, 9);
    chk("sat_hold", 32'(drop), 32'hFFFF);

    // Clear coinciding with a drop
    pmt = 1'b1;
    repeat (3) tick();
    pmt = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clear_vs_drop", 32'(drop), 32'd0);
    repeat (8) tick();
    chk("clear_vs_drop_later", 32'(drop), 32'd0);

    // Reset mid-operation: 5 queued, FSM in DEAD
    ready = 1'b1;
    repeat (3) tick();
    ready = 1'b0;
    chk("pre_reset_level", 32'(level), 32'd5);
    pmt = 1'b1;
    repeat (3) tick();
    pmt = 1'b0;
    tick();
    chk("pre_reset_dead", 32'(u_dut.state_q), 32'(DEAD));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_phase", phase, 32'd0);
    chk("arst_in_phase", 32'(ev_i), 32'd0);
    chk("arst_state", 32'(u_dut.state_q), 32'(ARMED));
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    pmt = 1'b1;
    repeat (3) tick();
    pmt = 1'b0;
    tick();
    chk("post_reset_lat3", 32'(valid), 32'd0);
    tick();
    chk("post_reset_lat4", 32'(valid), 32'd1);
    chk("post_reset_level", 32'(level), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pmt_pulse_capture.md
# pmt_pulse_capture

Front end of the photon-counting chain, placed between the PMT discriminator pin and the I/Q accumulation/waveform histogram stage. It synchronises the asynchronous `PMT_in` into the 50 MHz domain, glitch-filters it, and enforces a dead time. Each accepted photon is tagged with the modulation phase (`light_timer`, `in_phase`, `quadrature`) and queued in a small FIFO with a valid/ready handshake. The block also keeps saturating pile-up and overflow counters for the readout probes.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops on `PMT_in`, range 2–3.
- `MIN_HIGH`, 1: consecutive high synced samples needed to qualify a pulse, range 1–4.
- `DEAD_TIME`, 5: cycles after an accepted pulse during which edges are rejected, range ≥1.
- `FIFO_DEPTH`, 8: event FIFO entries, power of two.
- `PHASE_WIDTH`, 32: width of the `light_timer` tag.

Ports:
- `clock_50_mhz` input 1: sole clock, rising edge.
- `reset_n` input 1: asynchronous active-low reset.
- `PMT_in` input 1: asynchronous discriminator output.
- `light_timer` input PHASE_WIDTH: modulation phase counter, same clock domain.
- `in_phase` input 1: I reference level.
- `quadrature` input 1: Q reference level.
- `clear_counts` input 1: one-cycle pulse that zeroes `pileup_count` and `drop_count`.
- `event_valid` output 1: FIFO head valid.
- `event_ready` input 1: consumer accepts the head.
- `event_phase` output PHASE_WIDTH: `light_timer` tag of the head.
- `event_in_phase` output 1: `in_phase` tag of the head.
- `event_quadrature` output 1: `quadrature` tag of the head.
- `fifo_level` output clog2(FIFO_DEPTH)+1: occupancy.
- `pileup_count` output 16: edges rejected during dead time or while waiting for low, saturating.
- `drop_count` output 16: accepted pulses lost to a full FIFO, saturating.

## Operation
- **Synchroniser:** `SYNC_STAGES` flops give the synced input `s`; reset value 0.
- **Filter:** a counter runs up to `MIN_HIGH` while `s`=1 and clears when `s`=0. The filtered level `f` is 1 when the count reaches `MIN_HIGH` and 0 when `s` is 0. The rising edge `rise` = `f & ~f_d`.
- **FSM** (reset state ARMED):
  - ARMED: on `rise`, accept the pulse, push {light_timer, in_phase, quadrature} sampled in that cycle, load the dead counter with DEAD_TIME-1, and go to DEAD.
  - DEAD: decrement the counter. Any `rise` here increments `pileup_count`. At count 0 go to ARMED if `f`=0, otherwise to WAIT_LOW.
  - WAIT_LOW: stay until `f`=0, then go to ARMED. A `rise` cannot occur while `f` is high.
- **Tag:** the tag is taken at the detection cycle. The consumer subtracts the constant latency L (below) modulo its modulation period; no compensation is done here.
- **FIFO** (registered head):
  - A push when not full is stored.
  - A push when full is discarded and `drop_count` increments, except when a pop happens in the same cycle: a simultaneous push and pop while full is legal and both succeed.
  - A pop occurs when `event_valid & event_ready`. Pop when empty has no effect.
  - `fifo_level` is exact every cycle. Pointers wrap modulo FIFO_DEPTH.
- **Counters:** both saturate at 0xFFFF. `clear_counts` has priority over a same-cycle increment: the result is 0.
- **Reset:** assertion mid-operation empties the FIFO, returns the FSM to ARMED, and zeroes all counters and synchroniser flops. All outputs reset to 0.

## Timing
- **Latency:** from the first `PMT_in` sample that is high at a rising clock edge k to `rise`: SYNC_STAGES+MIN_HIGH cycles. `event_valid` rises one cycle later, so L = SYNC_STAGES+MIN_HIGH+1 (4 with defaults), when the FIFO was empty.
- **Minimum spacing:** two accepted pulses are at least DEAD_TIME+1 cycles apart, plus any time spent in WAIT_LOW.
- **Pulse width:** pulses shorter than MIN_HIGH cycles after synchronisation are never counted, in any state.
- **Head outputs:** `event_*` stay stable while `event_valid`=1 and `event_ready`=0. Throughput is one pop per cycle.
- **Same-cycle updates:** `pileup_count` and `drop_count` update in the cycle after the causing event.

## Structure
- Package `fluorescence_pkg` holds:
  - the FSM state enum {ARMED, DEAD, WAIT_LOW};
  - the event record type (phase, in_phase, quadrature);
  - `CNT_W=16`;
  - a saturating-increment function.
- One sub-module, `pulse_event_fifo`: a parameterised width/depth synchronous FIFO with valid/ready, level, and full. Its width comes from the package.

## Test plan
- **Single pulse:** PMT_in high for 3 cycles with `light_timer`=100 at detection → one event with phase 100; `event_valid` rises exactly 4 cycles after the first high sample; `fifo_level`=1.
- **Glitch and pile-up:** with MIN_HIGH=2, a 1-cycle glitch → no event and no pileup. With defaults, a second rise 3 cycles after an accepted one → `pileup_count`=1 and one event only.
- **Stuck-high input:** PMT_in held high for 20 cycles → exactly one event; FSM passes through WAIT_LOW; ARMED again only after PMT_in falls.
- **Overflow:** `event_ready`=0 and 10 spaced pulses → `fifo_level`=8, `drop_count`=2. At full, a push with a same-cycle pop → level stays 8 and `drop_count` is unchanged.
- **Clear priority:** `drop_count` held at 0xFFFF with more drops → stays 0xFFFF. `clear_counts` coinciding with a drop → 0.
- **Reset mid-operation:** `reset_n` low while the FSM is in DEAD with 5 queued events → all outputs 0 immediately (asynchronous). After release, a new pulse is accepted with latency 4.
